lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the execute stage and the word-wide data memory.

---
 rtl/lsu_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit bridging byte-addressed RV32I requests to a word-wide memory
// Loads are lane-extracted and extended; SB/SH use read-modify-write; faults answer without touching memory.
`timescale 1ns/1ps
module lsu_mem_ctrl #(
   parameter int WORD_IDX_W = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misalign,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_EXT  = 3'd2,
      S_WR   = 3'd3,
      S_RESP = 3'd4
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [15:0] r_wdata;

   logic        w_accept;
   logic        w_illegal;
   logic        w_misaligned;
   logic        w_fault;
   logic        w_is_sw;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic [31:0] w_merged;
   logic [31:0] w_word_idx;
   logic        w_unused_addr;

   assign w_accept   = req_valid & req_ready;
   assign w_word_idx = {{(32 - WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
   // Upper address bits alias onto the same word; they are deliberately dropped.
   assign w_unused_addr = ^req_addr[31:WORD_IDX_W+2];

   always_comb begin
      w_illegal = 1'b1;
      if (req_we) begin
         w_illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
      end else begin
         w_illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                       req_funct3 == F3_BU || req_funct3 == F3_HU);
      end
   end

   assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_fault      = w_illegal | w_misaligned;
   assign w_is_sw      = req_we && (req_funct3 == F3_W);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_fault)      w_next = S_RESP;
               else if (w_is_sw) w_next = S_WR;
               else              w_next = S_RD;
            end
         end
         S_RD:    w_next = S_EXT;
         S_EXT:   w_next = r_we ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      case (r_state)
         S_IDLE:  req_ready = 1'b1;
         S_WR:    mem_we    = 1'b1;
         S_RESP:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_byte = 8'h00;
      case (r_off)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
   end

   assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_load_ext = 32'h0;
      case (r_funct3)
         F3_B:    w_load_ext = {{24{w_byte[7]}}, w_byte};
         F3_H:    w_load_ext = {{16{w_half[15]}}, w_half};
         F3_W:    w_load_ext = mem_rdata;
         F3_BU:   w_load_ext = {24'h0, w_byte};
         F3_HU:   w_load_ext = {16'h0, w_half};
         default: w_load_ext = 32'h0;
      endcase
   end

   // Old word with the store lane(s) overlaid; only SB/SH ever reach EXT as stores.
   always_comb begin
      w_merged = mem_rdata;
      if (r_funct3[1:0] == 2'b00) begin
         w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_funct3[1:0] == 2'b01) begin
         w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_wdata      <= 16'h0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
         rsp_rdata    <= 32'h0;
         rsp_misalign <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we         <= req_we;
                  r_funct3     <= req_funct3;
                  r_off        <= req_addr[1:0];
                  r_wdata      <= req_wdata[15:0];
                  mem_addr     <= w_word_idx;
                  rsp_rdata    <= 32'h0;
                  rsp_misalign <= w_fault;
                  if (w_is_sw && !w_fault) begin
                     mem_wdata <= req_wdata;
                  end
               end
            end
            S_EXT: begin
               if (r_we) mem_wdata <= w_merged;
               else      rsp_rdata <= w_load_ext;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl against a 256-word memory model
// Memory word i is preset to i on the first clock.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misalign;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata = 32'h0;

   int errors = 0;
   int checks = 0;
   int we_count = 0;
   logic preset_done = 1'b0;
   logic [31:0] mem [0:255];

   typedef struct {
      logic [31:0] d;
      logic        m;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   lsu_mem_ctrl #(.WORD_IDX_W(8)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always @(posedge CLK) begin
      if (!preset_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= i;
         preset_done <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         mem_rdata <= mem_wdata;
         we_count <= we_count + 1;
      end else begin
         mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic em,
                        input int el);
      int g = 0;
      @(negedge CLK);
      while (!req_ready && g < 40) begin
         @(negedge CLK);
         g++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: got %0b want 1", req_ready);
      end
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      sb.push_back('{ed, em, el});
      @(posedge CLK);
      #1;
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b010;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic m, output int lat);
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!rsp_valid && lat < 20);
      d = rsp_rdata;
      m = rsp_misalign;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checks++;
      if ({rsp_valid, rsp_misalign, mem_we, req_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0001", {rsp_valid, rsp_misalign, mem_we, req_ready});
      end
      checks++;
      if (rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
      end
      checks++;
      if (mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
      end
      checks++;
      if (mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
      end
   endtask

   task automatic test_lw();
      logic [31:0] d;
      logic m;
      int lat;
      int we0;
      exp_t e;
      logic [31:0] addrs [2] = '{32'h0000_0014, 32'h8000_0018};
      logic [31:0] exps  [2] = '{32'h0000_0005, 32'h0000_0006};
      we0 = we_count;
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, 3'b010, addrs[k], 32'h0, exps[k], 1'b0, 3);
         wait_rsp(d, m, lat);
         e = sb.pop_front();
         checks++;
         if (d !== e.d) begin errors++; $display("FAIL lw_data[%0d]: got %h want %h", k, d, e.d); end
         checks++;
         if (m !== e.m) begin errors++; $display("FAIL lw_mis[%0d]: got %b want %b", k, m, e.m); end
         checks++;
         if (lat != e.lat) begin errors++; $display("FAIL lw_lat[%0d]: got %0d want %0d", k, lat, e.lat); end
      end
      checks++;
      if (we_count != we0) begin
         errors++;
         $display("FAIL lw_no_write: got %0d writes want 0", we_count - we0);
      end
   endtask

   task automatic test_sw_loads();
      logic [31:0] d;
      logic m;
      int lat;
      exp_t e;
      logic [2:0]  f3s   [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] addrs [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps  [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      wait_rsp(d, m, lat);
      e = sb.pop_front();
      checks++;
      if ({d, m} !== {e.d, e.m}) begin errors++; $display("FAIL sw_rsp: got %h/%b want %h/%b", d, m, e.d, e.m); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL sw_lat: got %0d want %0d", lat, e.lat); end
      for (int k = 0; k < 5; k++) begin
         issue(1'b0, f3s[k], addrs[k], 32'h0, exps[k], 1'b0, 3);
         wait_rsp(d, m, lat);
         e = sb.pop_front();
         checks++;
         if (d !== e.d) begin errors++; $display("FAIL ext_data[%0d]: got %h want %h", k, d, e.d); end
         checks++;
         if (m !== e.m || lat != e.lat) begin
            errors++;
            $display("FAIL ext_mis_lat[%0d]: got %b/%0d want %b/%0d", k, m, lat, e.m, e.lat);
         end
      end
   endtask

   task automatic test_sb();
      logic [31:0] d;
      logic m;
      int lat;
      int we0;
      exp_t e;
      we0 = we_count;
      issue(1'b1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 1'b0, 4);
      wait_rsp(d, m, lat);
      e = sb.pop_front();
      checks++;
      if ({d, m} !== {e.d, e.m}) begin errors++; $display("FAIL sb_rsp: got %h/%b want %h/%b", d, m, e.d, e.m); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL sb_lat: got %0d want %0d", lat, e.lat); end
      @(negedge CLK);
      checks++;
      if (we_count - we0 != 1) begin errors++; $display("FAIL sb_we_cycles: got %0d want 1", we_count - we0); end
      checks++;
      if (mem[8] !== 32'h0000AA08) begin errors++; $display("FAIL sb_word8: got %h want 0000aa08", mem[8]); end
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h0000AA08, 1'b0, 3);
      wait_rsp(d, m, lat);
      e = sb.pop_front();
      checks++;
      if (d !== e.d || lat != e.lat) begin
         errors++;
         $display("FAIL sb_readback: got %h/%0d want %h/%0d", d, lat, e.d, e.lat);
      end
   endtask

   task automatic test_sh_fault();
      logic [31:0] d;
      logic m;
      int lat;
      int we0;
      exp_t e;
      logic        wes   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3s   [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
      logic [31:0] addrs [5] = '{32'h15, 32'h22, 32'h00, 32'h00, 32'h11};
      issue(1'b1, 3'b001, 32'h26, 32'h0000CAFE, 32'h0, 1'b0, 4);
      wait_rsp(d, m, lat);
      e = sb.pop_front();
      checks++;
      if ({d, m} !== {e.d, e.m} || lat != e.lat) begin
         errors++;
         $display("FAIL sh_rsp: got %h/%b/%0d want %h/%b/%0d", d, m, lat, e.d, e.m, e.lat);
      end
      @(negedge CLK);
      checks++;
      if (mem[9] !== 32'hCAFE0009) begin errors++; $display("FAIL sh_word9: got %h want cafe0009", mem[9]); end
      we0 = we_count;
      for (int k = 0; k < 5; k++) begin
         issue(wes[k], f3s[k], addrs[k], 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
         wait_rsp(d, m, lat);
         e = sb.pop_front();
         checks++;
         if ({d, m} !== {e.d, e.m}) begin
            errors++;
            $display("FAIL fault_rsp[%0d]: got %h/%b want %h/%b", k, d, m, e.d, e.m);
         end
         checks++;
         if (lat != e.lat) begin errors++; $display("FAIL fault_lat[%0d]: got %0d want %0d", k, lat, e.lat); end
      end
      @(negedge CLK);
      checks++;
      if (we_count != we0) begin errors++; $display("FAIL fault_no_write: got %0d writes want 0", we_count - we0); end
   endtask

   task automatic test_rst_abort();
      int we0;
      int g = 0;
      we0 = we_count;
      @(negedge CLK);
      while (!req_ready && g < 40) begin
         @(negedge CLK);
         g++;
      end
      req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h0000_1234; req_valid = 1'b1;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checks++;
      if ({req_ready, rsp_valid, mem_we} !== 3'b100) begin
         errors++;
         $display("FAIL abort_ctrl: got %b want 100", {req_ready, rsp_valid, mem_we});
      end
      checks++;
      if (mem_wdata !== 32'h0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL abort_mem_out: got %h/%h want 0/0", mem_addr, mem_wdata);
      end
      repeat (5) @(negedge CLK);
      checks++;
      if (we_count != we0) begin errors++; $display("FAIL abort_no_write: got %0d writes want 0", we_count - we0); end
      checks++;
      if (mem[12] !== 32'h0000000C) begin errors++; $display("FAIL abort_word12: got %h want 0000000c", mem[12]); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int cnt;
      int rdy;
      logic [31:0] addrs [3] = '{32'h04, 32'h08, 32'h0C};
      logic [31:0] exps  [3] = '{32'h1, 32'h2, 32'h3};
      @(negedge CLK);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = addrs[0]; req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{exps[k], 1'b0, (k == 0) ? 3 : 4});
         cnt = 0;
         rdy = 0;
         do begin
            if (req_ready) rdy++;
            @(negedge CLK);
            cnt++;
         end while (!rsp_valid && cnt < 30);
         e = sb.pop_front();
         checks++;
         if (rsp_rdata !== e.d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rsp_rdata, e.d); end
         checks++;
         if (cnt != e.lat || rdy != 1) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got cycles=%0d ready=%0d want cycles=%0d ready=1", k, cnt, rdy, e.lat);
         end
         if (k < 2) req_addr = addrs[k+1];
         else       req_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lw();
      test_sw_loads();
      test_sb();
      test_sh_fault();
      test_rst_abort();
      test_back_to_back();
      repeat (2) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
